// File: rtl/bp_be_mem_issue_sched.sv
// Memory-pipe issue arbiter between core and page-table-walker requests, with
// starvation protection, fence ordering, 2-stage in-flight tracking and miss handling.
module bp_be_mem_issue_sched #(
  parameter int unsigned ptw_starve_limit_p = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       flush_i,
  input  logic       core_v_i,
  input  logic       core_fence_i,
  output logic       core_ready_and_o,
  input  logic       ptw_v_i,
  output logic       ptw_ready_and_o,
  input  logic       busy_i,
  input  logic       ordered_i,
  input  logic       miss_i,
  input  logic       replay_i,
  output logic       issue_v_o,
  output logic       issue_sel_o,
  output logic [1:0] inflight_o,
  output logic       state_o
);

  typedef enum logic {
    RUN       = 1'b0,
    MISS_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] starve_limit_lp = 4'(ptw_starve_limit_p);

  state_e     state_q;
  logic [3:0] starve_q, starve_d;
  logic       s0_v_q, s0_src_q, s0_v_d, s0_src_d;
  logic       s1_v_q, s1_src_q, s1_v_d, s1_src_d;

  logic       can_grant;
  logic       core_ok;
  logic       core_starved;
  logic       core_gnt;
  logic       ptw_gnt;
  logic       squash;
  logic [1:0] inflight;

  assign inflight  = {1'b0, s0_v_q} + {1'b0, s1_v_q};
  assign can_grant = (state_q == RUN) & ~busy_i & ~reset_i;

  // A fence may only go out once the pipe is drained and the D$ reports ordering.
  assign core_ok      = core_v_i & (~core_fence_i | ((inflight == 2'd0) & ordered_i));
  assign core_starved = core_v_i & (starve_q == starve_limit_lp);

  // PTW normally wins; a starved core takes the slot only if it can actually issue.
  assign core_gnt = can_grant & core_ok & (core_starved | ~ptw_v_i);
  assign ptw_gnt  = can_grant & ptw_v_i & ~(core_ok & core_starved);

  assign core_ready_and_o = core_gnt;
  assign ptw_ready_and_o  = ptw_gnt;
  assign issue_v_o        = core_gnt | ptw_gnt;
  assign issue_sel_o      = ptw_gnt;
  assign inflight_o       = inflight;
  assign state_o          = state_q;

  // Misses are ignored once waiting, so only a RUN-state report squashes.
  assign squash = (state_q == RUN) & (miss_i | replay_i);

  always_comb begin
    starve_d = starve_q;
    if (!core_v_i || core_gnt) begin
      starve_d = 4'd0;
    end else if (ptw_gnt && (starve_q < starve_limit_lp)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    s0_v_d   = issue_v_o & ~(flush_i & ~issue_sel_o);
    s0_src_d = issue_sel_o;
    s1_v_d   = s0_v_q & ~squash & ~(flush_i & ~s0_src_q);
    s1_src_d = s0_src_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:       if (squash) state_q <= MISS_WAIT;
        MISS_WAIT: if (!busy_i) state_q <= RUN;
        default:   state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_q <= 4'd0;
      s0_v_q   <= 1'b0;
      s0_src_q <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_src_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      s0_v_q   <= s0_v_d;
      s0_src_q <= s0_src_d;
      s1_v_q   <= s1_v_d;
      s1_src_q <= s1_src_d;
    end
  end

endmodule
